apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB initiator. Converts a single-outstanding command/response stream into APB SETUP/ACCESS transfers driven onto the slave-side APB signals.
- Used as the bus driver for register blocks, and as a synthesizable stimulus master in integration benches.
- Includes alignment checking, a wait-state timeout, and response back-pressure.

Parameters:
- ADDR_WIDTH, 16, width of cmd_addr/paddr (≤ APB_MAX_ADDR_WIDTH).
- DATA_WIDTH, 32, width of wdata/rdata; must be 8, 16 or 32.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; the only clock.
- preset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors).
- rsp_err  out  1  slave error, misalignment or timeout.
- rsp_timeout  out  1  error cause was a timeout.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Reset: asynchronous on preset_n low. State=IDLE. All outputs 0 except cmd_ready, which is 1 once out of reset. Reset during any state aborts the transfer immediately: psel and penable drop in the same instant, and any pending response is discarded.
- Registered outputs: all APB outputs and rsp_* come from flops. cmd_ready is a decode of state (1 only in IDLE).
- IDLE:
  - On a cmd handshake, latch addr/write/wdata.
  - If cmd_addr[log2(DATA_WIDTH/8)-1:0] != 0: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB activity (psel stays 0).
  - Otherwise go to SETUP.
- SETUP (1 cycle): psel=1, penable=0; paddr/pwrite/pwdata valid. pwdata=0 for reads. Next state ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable until exit.
  - pready=1: capture prdata (reads only; 0 for writes) and pslverr into rsp_rdata/rsp_err. Go to RESP; psel=penable=0 on the next cycle.
  - pslverr=1 forces rsp_rdata=0.
  - Wait counter increments each ACCESS cycle with pready=0 and is cleared on entering SETUP. Width is $clog2(TIMEOUT_CYCLES+1).
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with pready still 0: abort. psel=penable=0 next cycle; RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0. A pready arriving in the same cycle as expiry wins: normal completion.
- RESP: rsp_valid=1. rsp_* held stable until rsp_ready. On handshake, rsp_valid=0 next cycle and return to IDLE (cmd_ready=1 that cycle). No new command is accepted while in RESP.
- Latency (aligned, zero wait states, rsp_ready=1):
  - cmd handshake at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3, cmd_ready again at cycle 4.
  - A back-to-back command has its SETUP at cycle 5.
- Throughput: one outstanding transfer. Back-to-back APB transfers always separated by at least 2 idle bus cycles.
- penable is never 1 while psel is 0. psel never rises with penable already 1.

Decomposition:
- Package apb_master_pkg:
  - state enum apb_state_t {IDLE, SETUP, ACCESS, RESP}.
  - Function addr_lsb_bits(DATA_WIDTH) returning the alignment width.
  - Response struct apb_rsp_t {rdata, err, timeout}.
- Sub-module apb_wait_timer: parameter TIMEOUT_CYCLES; inputs clr, inc; output expired. Tied off (expired=0) when TIMEOUT_CYCLES=0.

Test Plan:
- Write addr=0x0010, wdata=0xDEADBEEF, slave pready=1 immediately:
  - psel rises 1 cycle after handshake, penable 1 cycle later, rsp_valid at cycle 3.
  - rsp_err=0, rsp_rdata=0.
- Read addr=0x0024, slave inserts 3 wait states then prdata=0xA5A5_0F0F:
  - paddr/pwrite stable throughout; rsp_rdata=0xA5A50F0F at cycle 6; rsp_err=0.
- Read addr=0x0013 (misaligned, DATA_WIDTH=32):
  - psel never asserts; rsp_valid at cycle 1 with rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, pready held 0:
  - bus dropped after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with pready=1 on the expiry cycle: normal completion, rsp_timeout=0.
- Write with pslverr=1 and rsp_ready held 0 for 5 cycles:
  - rsp_valid/rsp_err=1 stable for 5 cycles; cmd_ready=0 until the cycle after the handshake.
- preset_n pulsed low during ACCESS:
  - psel/penable/rsp_valid go 0 asynchronously; after release, cmd_ready=1 and the next command runs normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB initiator: FSM states, response record,
// and the address-alignment width helper.
package apb_master_pkg;

    localparam int unsigned APB_MAX_ADDR_WIDTH = 32;
    localparam int unsigned APB_MAX_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    typedef struct packed {
        logic [APB_MAX_DATA_WIDTH-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } apb_rsp_t;

    // Number of low address bits that must be zero for a full-width access.
    function automatic int unsigned addr_lsb_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB bus signals of the APB initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, pwrite, psel, penable, pwdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter. expired flags the waiting cycle that would bring
// the count to TIMEOUT_CYCLES; TIMEOUT_CYCLES=0 disables it entirely.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        assign expired = 1'b0;
    end else begin : g_on
        localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);
        localparam logic [CntW-1:0] Max   = CntW'(TIMEOUT_CYCLES);

        logic [CntW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != Max)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired = inc && (cnt_q == Limit);
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns a single-outstanding command/response stream into
// SETUP/ACCESS transfers, with alignment check, wait timeout and back-pressure.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         pclk,
    input  logic         preset_n,
    apb_master_if.master bus
);

    localparam int unsigned LsbW = addr_lsb_bits(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'((1 << LsbW) - 1);

    apb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    apb_rsp_t              rsp_q, rsp_d;

    logic cmd_fire, misaligned;
    logic timer_clr, timer_inc, timer_expired;

    assign misaligned = (bus.cmd_addr & AlignMask) != '0;
    assign cmd_fire   = bus.cmd_valid && (state_q == IDLE);
    assign timer_clr  = cmd_fire && !misaligned;
    assign timer_inc  = (state_q == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk    (pclk),
        .preset_n(preset_n),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rsp_d    = rsp_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    if (misaligned) begin
                        state_d = RESP;
                        rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A pready in the expiry cycle still completes normally.
                if (bus.pready) begin
                    state_d       = RESP;
                    rsp_d.rdata   = (pwrite_q || bus.pslverr) ? '0
                                                              : APB_MAX_DATA_WIDTH'(bus.prdata);
                    rsp_d.err     = bus.pslverr;
                    rsp_d.timeout = 1'b0;
                end else if (timer_expired) begin
                    state_d = RESP;
                    rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rsp_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus controls are registered images of the next state.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.cmd_ready   = preset_n && (state_q == IDLE);
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Scenario-driven bench for apb_master: expected responses are queued when a
// command is issued and compared when the response appears.
module tb_apb_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } exp_t;

    logic pclk;
    logic preset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    apb_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic drive_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
    endtask

    task automatic test_reset;
        preset_n      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
        repeat (2) @(negedge pclk);
        n_tests++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
        n_tests++;
        if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== '0)
            $display("FAIL reset_data: got %h/%h/%h want 0", bus.paddr, bus.pwdata, bus.rsp_rdata);
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000 ||
            {bus.paddr, bus.pwdata, bus.rsp_rdata} !== '0) n_fail++;
        preset_n = 1'b1;
        @(negedge pclk);
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got cmd_ready=%b psel=%b want 1 0",
                     bus.cmd_ready, bus.psel);
        end
    endtask

    // Zero-wait write; ends in cycle 4 with the master idle again.
    task automatic test_write;
        exp_t e;
        drive_cmd(1'b1, 16'h0010, 32'hDEADBEEF);
        bus.pready    = 1'b1;
        bus.prdata    = 32'hFFFF_FFFF;
        bus.rsp_ready = 1'b1;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge pclk);  // cycle 1
        bus.cmd_valid = 1'b0;
        n_tests++;
        if ({bus.psel, bus.penable} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_setup: got psel/penable=%b want 10", {bus.psel, bus.penable});
        end
        n_tests++;
        if (bus.paddr !== 16'h0010 || bus.pwrite !== 1'b1 || bus.pwdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_bus: got %h/%b/%h want 0010/1/deadbeef",
                     bus.paddr, bus.pwrite, bus.pwdata);
        end
        @(negedge pclk);  // cycle 2
        n_tests++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL wr_access: got %b want 110", {bus.psel, bus.penable, bus.rsp_valid});
        end
        @(negedge pclk);  // cycle 3
        bus.pready = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if ({bus.rsp_valid, bus.psel, bus.penable} !== 3'b100 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL wr_rsp: got v=%b psel=%b rdata=%h err=%b to=%b want 1 0 %h %b %b",
                     bus.rsp_valid, bus.psel, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);  // cycle 4
        n_tests++;
        if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_done: got cmd_ready/rsp_valid=%b want 10",
                     {bus.cmd_ready, bus.rsp_valid});
        end
    endtask

    // Issued in cycle 4 of test_write, so its SETUP lands on cycle 5.
    task automatic test_back_to_back_read;
        exp_t e;
        drive_cmd(1'b0, 16'h0024, 32'h1111_2222);
        bus.pready = 1'b0;
        sb.push_back('{32'hA5A5_0F0F, 1'b0, 1'b0});
        @(negedge pclk);  // cycle 1
        bus.cmd_valid = 1'b0;
        n_tests++;
        if ({bus.psel, bus.penable} !== 2'b10 || bus.pwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_setup: got psel/penable=%b pwdata=%h want 10 0",
                     {bus.psel, bus.penable}, bus.pwdata);
        end
        for (int c = 2; c <= 5; c++) begin
            @(negedge pclk);
            n_tests++;
            if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid} !== 4'b1100 ||
                bus.paddr !== 16'h0024) begin
                n_fail++;
                $display("FAIL rd_wait_c%0d: got ctl=%b paddr=%h want 1100 0024", c,
                         {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid}, bus.paddr);
            end
            if (c == 5) begin
                bus.pready = 1'b1;
                bus.prdata = 32'hA5A5_0F0F;
            end
        end
        @(negedge pclk);  // cycle 6
        bus.pready = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL rd_rsp: got v=%b rdata=%h err=%b to=%b want 1 %h %b %b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);
    endtask

    task automatic test_misaligned;
        exp_t e;
        drive_cmd(1'b0, 16'h0013, 32'h0);
        sb.push_back('{32'h0, 1'b1, 1'b0});
        @(negedge pclk);  // cycle 1
        bus.cmd_valid = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if ({bus.rsp_valid, bus.psel} !== 2'b10 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL misalign_rsp: got v=%b psel=%b rdata=%h err=%b to=%b want 1 0 %h %b %b",
                     bus.rsp_valid, bus.psel, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);  // cycle 2
        n_tests++;
        if ({bus.cmd_ready, bus.psel, bus.rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL misalign_done: got %b want 100",
                     {bus.cmd_ready, bus.psel, bus.rsp_valid});
        end
    endtask

    // ACCESS covers cycles 2..17; cycle 17 is the expiry cycle.
    task automatic test_timeout(input bit late_ready);
        exp_t e;
        int   bad;
        drive_cmd(1'b0, 16'h0080, 32'h0);
        bus.pready = 1'b0;
        if (late_ready) sb.push_back('{32'h5A5A_1234, 1'b0, 1'b0});
        else            sb.push_back('{32'h0, 1'b1, 1'b1});
        @(negedge pclk);  // cycle 1
        bus.cmd_valid = 1'b0;
        bad = 0;
        for (int c = 2; c <= 17; c++) begin
            @(negedge pclk);
            if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) bad++;
            if (c == 17 && late_ready) begin
                bus.pready = 1'b1;
                bus.prdata = 32'h5A5A_1234;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL to_access_len(late=%0d): got %0d bad cycles want 0", late_ready, bad);
        end
        @(negedge pclk);  // cycle 18
        bus.pready = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b001 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL to_rsp(late=%0d): got ctl=%b rdata=%h err=%b to=%b want 001 %h %b %b",
                     late_ready, {bus.psel, bus.penable, bus.rsp_valid}, bus.rsp_rdata,
                     bus.rsp_err, bus.rsp_timeout, e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);
    endtask

    task automatic test_slverr_backpressure;
        exp_t e;
        int   bad;
        drive_cmd(1'b1, 16'h0040, 32'hCAFE_F00D);
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b1;
        bus.prdata    = 32'h1234_5678;
        bus.rsp_ready = 1'b0;
        sb.push_back('{32'h0, 1'b1, 1'b0});
        @(negedge pclk);  // cycle 1
        bus.cmd_valid = 1'b0;
        @(negedge pclk);  // cycle 2
        bad = 0;
        for (int c = 3; c <= 7; c++) begin
            @(negedge pclk);
            bus.pready = 1'b0;
            if ({bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.psel} !== 4'b1100 ||
                bus.rsp_rdata !== 32'h0) bad++;
            if (c == 7) bus.rsp_ready = 1'b1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL slverr_hold: got %0d bad cycles want 0", bad);
        end
        e = sb.pop_front();
        n_tests++;
        if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL slverr_rsp: got rdata=%h err=%b to=%b want %h %b %b",
                     bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);  // cycle 8
        n_tests++;
        if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL slverr_done: got %b want 10", {bus.cmd_ready, bus.rsp_valid});
        end
        // Read with slave error: rdata must be zeroed despite nonzero prdata.
        drive_cmd(1'b0, 16'h0044, 32'h0);
        bus.pready = 1'b1;
        sb.push_back('{32'h0, 1'b1, 1'b0});
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL slverr_rd: got v=%b rdata=%h err=%b to=%b want 1 %h %b %b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);
    endtask

    task automatic test_reset_abort;
        exp_t e;
        drive_cmd(1'b0, 16'h0050, 32'h0);
        bus.pready = 1'b0;
        @(negedge pclk);  // cycle 1
        bus.cmd_valid = 1'b0;
        @(negedge pclk);  // cycle 2, ACCESS
        n_tests++;
        if ({bus.psel, bus.penable} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_pre: got %b want 11", {bus.psel, bus.penable});
        end
        #1 preset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_async: got %b want 000", {bus.psel, bus.penable, bus.rsp_valid});
        end
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        n_tests++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.psel} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_release: got %b want 100",
                     {bus.cmd_ready, bus.rsp_valid, bus.psel});
        end
        drive_cmd(1'b1, 16'h0060, 32'h0102_0304);
        bus.pready = 1'b1;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        n_tests++;
        if ({bus.psel, bus.penable} !== 2'b10 || bus.paddr !== 16'h0060 ||
            bus.pwdata !== 32'h0102_0304) begin
            n_fail++;
            $display("FAIL abort_next_setup: got %b %h %h want 10 0060 01020304",
                     {bus.psel, bus.penable}, bus.paddr, bus.pwdata);
        end
        @(negedge pclk);
        @(negedge pclk);
        bus.pready = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.timeout}) begin
            n_fail++;
            $display("FAIL abort_next_rsp: got v=%b rdata=%h err=%b to=%b want 1 %h %b %b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     e.rdata, e.err, e.timeout);
        end
        @(negedge pclk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back_read();
        test_misaligned();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_slverr_backpressure();
        test_reset_abort();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1);
    end

endmodule
